// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: lock-state encoding and round-robin search shared by the arbiter
package stream_arb_pkg;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_e;

    localparam int MAX_REQ = 16;

    // First set bit of val searching upward from last+1 with wrap-around over n requesters
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] val, input logic [3:0] last, input int n);
        rr_pick = last;
        for (int k = MAX_REQ; k >= 1; k--)
            if (k <= n && val[(int'(last) + k) % n])
                rr_pick = 4'((int'(last) + k) % n);
    endfunction

endpackage

// File: rtl/skid_register.sv
// skid_register: two-entry valid/ready output stage (output register plus skid)
module skid_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_val,
    output logic             up_rdy,
    output logic [WIDTH-1:0] dn_data,
    output logic             dn_val,
    input  logic             dn_rdy
);

    logic             out_val, skid_val, rdy, load, xfer;
    logic [WIDTH-1:0] out_data, skid_data;

    assign load    = ~out_val | dn_rdy;
    assign xfer    = up_val & rdy;
    assign up_rdy  = rdy;
    assign dn_val  = out_val;
    assign dn_data = out_data;

    // Occupancy and registered ready; ready stays low for the first cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val  <= 1'b0;
            skid_val <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            rdy <= load | ~(skid_val | xfer);
            if (load) begin
                out_val  <= skid_val | xfer;
                skid_val <= 1'b0;
            end else if (xfer) begin
                skid_val <= 1'b1;
            end
        end
    end

    // Payload registers: output drains the skid first to keep beat order
    always_ff @(posedge clk) begin
        if (load)
            out_data <= skid_val ? skid_data : up_data;
        if (xfer && !load)
            skid_data <= up_data;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin N-to-1 stream arbiter; STREAM_ARB_PKT_LOCK_EN adds packet locking
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] up_bus,
    input  logic [NUM_REQ-1:0]            up_val,
    input  logic [NUM_REQ-1:0]            up_last,
    output logic [NUM_REQ-1:0]            up_rdy,
    output logic [DATA_WIDTH-1:0]         dn_bus,
    output logic [$clog2(NUM_REQ)-1:0]    dn_src,
    output logic                          dn_last,
    output logic                          dn_val,
    input  logic                          dn_rdy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = DATA_WIDTH + IW + 1;

    logic [IW-1:0] last_grant, rr, winner;
    logic          sel_val, stage_rdy, xfer;
    logic [PW-1:0] stage_in, stage_out;

    assign rr       = IW'(rr_pick(MAX_REQ'(up_val), 4'(last_grant), NUM_REQ));
    assign sel_val  = up_val[winner];
    assign xfer     = sel_val & stage_rdy;
    assign up_rdy   = xfer ? NUM_REQ'(1) << winner : '0;
    assign stage_in = {winner, up_last[winner], up_bus[winner*DATA_WIDTH +: DATA_WIDTH]};
    assign {dn_src, dn_last, dn_bus} = stage_out;

`ifdef STREAM_ARB_PKT_LOCK_EN
    lock_state_e   state;
    logic [IW-1:0] lock_id;

    assign winner = (state == LOCKED) ? lock_id : rr;

    // Packet lock FSM: hold the grant until the locked requester sends its last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lock_id    <= '0;
            last_grant <= IW'(NUM_REQ - 1);
        end else if (xfer) begin
            if (up_last[winner]) begin
                state      <= IDLE;
                last_grant <= winner;
            end else begin
                state   <= LOCKED;
                lock_id <= winner;
            end
        end
    end
`else
    assign winner = rr;

    // Round-robin pointer advances only when a beat is actually accepted
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= IW'(NUM_REQ - 1);
        else if (xfer)
            last_grant <= winner;
    end
`endif

    skid_register #(.WIDTH(PW)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .up_data (stage_in),
        .up_val  (sel_val),
        .up_rdy  (stage_rdy),
        .dn_data (stage_out),
        .dn_val  (dn_val),
        .dn_rdy  (dn_rdy)
    );

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed checks of round-robin order, backpressure, reset and packet lock
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct packed {logic [1:0] src; logic last; logic [DW-1:0] data;} beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N*DW-1:0] up_bus;
    logic [N-1:0]  up_val = '0;
    logic [N-1:0]  up_last = '1;
    logic [N-1:0]  up_rdy;
    logic [DW-1:0] dn_bus;
    logic [1:0]    dn_src;
    logic          dn_last, dn_val;
    logic          dn_rdy = 1'b0;

    int            n_chk = 0, n_pass = 0, cyc = 0, n_acc = 0;
    logic [5:0]    seq [N];
    logic [N-1:0]  xm = '0, rdy_seen = '0;
    bit            pkt3 = 0;
    beat_t         sb[$];
    int            src_log[$], cyc_log[$];
    logic [DW-1:0] dat_log[$];

    stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .up_bus  (up_bus),
        .up_val  (up_val),
        .up_last (up_last),
        .up_rdy  (up_rdy),
        .dn_bus  (dn_bus),
        .dn_src  (dn_src),
        .dn_last (dn_last),
        .dn_val  (dn_val),
        .dn_rdy  (dn_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            up_bus[i*DW +: DW] = {2'(i), seq[i]};
            up_last[i] = pkt3 ? (seq[i] % 3 == 2) : 1'b1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (xm[i]) seq[i]++;
            drive();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        for (int i = 0; i < N; i++) seq[i] = '0;
        drive();
        rst = 1'b0;
        src_log.delete(); dat_log.delete(); cyc_log.delete();
        rdy_seen = '0;
        n_acc = 0;
    endtask

    // Scoreboard: every accepted beat must come out once, in order, with its source and last flag
    always @(negedge clk) begin
        cyc++;
        xm = '0;
        if (rst) begin
            sb.delete();
        end else begin
            chk("onehot0_up_rdy", 32'($onehot0(up_rdy)), 1);
            rdy_seen |= up_rdy;
            if (dn_val && dn_rdy) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("sb_beat", 32'({dn_src, dn_last, dn_bus}), 32'(sb[0]));
                    void'(sb.pop_front());
                end
                src_log.push_back(int'(dn_src));
                dat_log.push_back(dn_bus);
                cyc_log.push_back(cyc);
            end
            xm = up_val & up_rdy;
            for (int i = 0; i < N; i++)
                if (xm[i]) begin
                    sb.push_back({2'(i), up_last[i], up_bus[i*DW +: DW]});
                    n_acc++;
                end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) seq[i] = '0;
        drive();

        // reset state and dead first cycle, then all requesters streaming
        up_val = 4'b1111;
        dn_rdy = 1'b1;
        step(1);
        @(negedge clk);
        chk("rst_dn_val", 32'(dn_val), 0);
        chk("rst_up_rdy", 32'(up_rdy), 0);
        do_reset();
        @(negedge clk);
        chk("post_rst_up_rdy", 32'(up_rdy), 0);
        step(12);
        chk("t1_count", 32'(src_log.size() >= 8), 1);
        if (src_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) chk("t1_src", 32'(src_log[i]), 32'(i % 4));
            chk("t1_rate", 32'(cyc_log[7] - cyc_log[0]), 7);
            chk("t1_dat0", 32'(dat_log[0]), 32'h00);
            chk("t1_dat1", 32'(dat_log[1]), 32'h40);
            chk("t1_dat4", 32'(dat_log[4]), 32'h01);
        end

        // sparse requesters 0 and 2 alternate
        up_val = 4'b0101;
        do_reset();
        step(12);
        chk("t2_count", 32'(src_log.size() >= 6), 1);
        if (src_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk("t2_src", 32'(src_log[i]), 32'((i % 2) * 2));
            chk("t2_dat2", 32'(dat_log[2]), 32'h01);
            chk("t2_dat3", 32'(dat_log[3]), 32'h81);
        end
        chk("t2_rdy_1_3", 32'(rdy_seen & 4'b1010), 0);

        // downstream stalled: exactly two beats absorbed, output held
        up_val = 4'b1111;
        dn_rdy = 1'b0;
        do_reset();
        step(6);
        chk("t3_acc", 32'(n_acc), 2);
        @(negedge clk);
        chk("t3_up_rdy", 32'(up_rdy), 0);
        chk("t3_dn_val", 32'(dn_val), 1);
        chk("t3_dn_bus", 32'(dn_bus), 32'h00);
        chk("t3_dn_src", 32'(dn_src), 0);
        up_val = 4'b0000;
        dn_rdy = 1'b1;
        step(4);
        chk("t3_out_count", 32'(src_log.size()), 2);
        if (src_log.size() == 2) begin
            chk("t3_src0", 32'(src_log[0]), 0);
            chk("t3_src1", 32'(src_log[1]), 1);
            chk("t3_dat0", 32'(dat_log[0]), 32'h00);
            chk("t3_dat1", 32'(dat_log[1]), 32'h40);
        end

        // reset mid-operation discards buffered beats
        up_val = 4'b1111;
        dn_rdy = 1'b0;
        do_reset();
        step(4);
        chk("t4_acc", 32'(n_acc), 2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = '0;
        drive();
        src_log.delete(); dat_log.delete(); cyc_log.delete();
        @(negedge clk);
        chk("t4_dn_val", 32'(dn_val), 0);
        chk("t4_up_rdy", 32'(up_rdy), 0);
        dn_rdy = 1'b1;
        step(6);
        chk("t4_count", 32'(src_log.size() >= 1), 1);
        if (src_log.size() >= 1) chk("t4_first_src", 32'(src_log[0]), 0);

`ifdef STREAM_ARB_PKT_LOCK_EN
        // packet lock: requester 1 keeps the grant for its 3-beat packet
        pkt3 = 1;
        up_val = 4'b0110;
        do_reset();
        step(10);
        chk("t5_count", 32'(src_log.size() >= 4), 1);
        if (src_log.size() >= 4) begin
            chk("t5_src0", 32'(src_log[0]), 1);
            chk("t5_src1", 32'(src_log[1]), 1);
            chk("t5_src2", 32'(src_log[2]), 1);
            chk("t5_src3", 32'(src_log[3]), 2);
        end
        pkt3 = 0;
`endif

        up_val = '0;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
